// File: rtl/motor_axis_driver.sv
// -----------------------------------------------------------------------------
// motor_axis_driver
// Single-axis step/direction driver with homing. After reset the axis runs
// toward home until the limit switch trips. It then accepts absolute target
// coordinates and issues STEPS_PER_UNIT step pulses per coordinate unit.
//
// Ports
//   sysclk     in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   Stop       in   home limit switch, asynchronous, active-high
//   tgt_valid  in   target coordinate offered
//   tgt_pos    in   [9:0] target coordinate (legal 0..999)
//   tgt_ready  out  target can be accepted (IDLE and homed)
//   PU         out  step pulse
//   DR         out  direction, 1 = away from home
//   MF         out  motor free, 1 = driver de-energized
//   cur_pos    out  [9:0] current coordinate
//   homed      out  home position established
//   done       out  one-cycle move-finished / null-move pulse
//   err        out  one-cycle illegal-target pulse, held high in FAULT
// -----------------------------------------------------------------------------
module motor_axis_driver #(
    parameter int HALF_PERIOD    = 4,
    parameter int STEPS_PER_UNIT = 2,
    parameter int HOME_TIMEOUT   = 2048
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       Stop,
    input  logic       tgt_valid,
    input  logic [9:0] tgt_pos,
    output logic       tgt_ready,
    output logic       PU,
    output logic       DR,
    output logic       MF,
    output logic [9:0] cur_pos,
    output logic       homed,
    output logic       done,
    output logic       err
);

    localparam int HW  = $clog2(HALF_PERIOD + 1);
    localparam int SW  = $clog2(STEPS_PER_UNIT + 1);
    localparam int HCW = $clog2(HOME_TIMEOUT + 1);
    localparam logic [HW-1:0]  HALF_LAST = HW'(HALF_PERIOD - 1);
    localparam logic [SW-1:0]  STEP_LAST = SW'(STEPS_PER_UNIT - 1);
    localparam logic [HCW-1:0] HOME_LAST = HCW'(HOME_TIMEOUT - 1);
    localparam logic [9:0]     POS_MAX   = 10'd999;

    typedef enum logic [2:0] {
        S_HOME  = 3'd0,
        S_IDLE  = 3'd1,
        S_SETUP = 3'd2,
        S_MOVE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t         state_r, state_s;
    logic           stop_meta_r, stop_sync_r;
    logic [HW-1:0]  half_cnt_r, half_cnt_s;
    logic [SW-1:0]  step_cnt_r, step_cnt_s;
    logic [HCW-1:0] home_cnt_r, home_cnt_s;
    logic [9:0]     target_r, target_s;
    logic [9:0]     pos_r, pos_s;
    logic           pu_r, pu_s;
    logic           dr_r, dr_s;
    logic           mf_r, mf_s;
    logic           homed_r, homed_s;
    logic           done_r, done_s;
    logic           err_r, err_s;
    logic           ready_r, ready_s;
    logic           half_done_s;
    logic [9:0]     pos_step_s;

    assign half_done_s = (half_cnt_r == HALF_LAST);
    // DR is frozen for the whole move, so the next coordinate depends only on it
    assign pos_step_s  = dr_r ? (pos_r + 10'd1) : (pos_r - 10'd1);

    // Two-flop synchronizer for the asynchronous limit switch
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            stop_meta_r <= 1'b0;
            stop_sync_r <= 1'b0;
        end else begin
            stop_meta_r <= Stop;
            stop_sync_r <= stop_meta_r;
        end
    end

    // Next-state and next-output logic for the axis FSM
    always_comb begin
        state_s    = state_r;
        half_cnt_s = half_cnt_r;
        step_cnt_s = step_cnt_r;
        home_cnt_s = home_cnt_r;
        target_s   = target_r;
        pos_s      = pos_r;
        pu_s       = pu_r;
        dr_s       = dr_r;
        mf_s       = 1'b0;
        homed_s    = homed_r;
        done_s     = 1'b0;
        err_s      = 1'b0;
        case (state_r)
            S_HOME: begin
                dr_s = 1'b0;
                if (stop_sync_r) begin
                    // a partially issued pulse is simply dropped
                    pu_s       = 1'b0;
                    pos_s      = 10'd0;
                    homed_s    = 1'b1;
                    half_cnt_s = '0;
                    state_s    = S_IDLE;
                end else if (half_done_s) begin
                    half_cnt_s = '0;
                    pu_s       = ~pu_r;
                    if (pu_r) begin
                        if (home_cnt_r == HOME_LAST) begin
                            state_s = S_FAULT;
                            pu_s    = 1'b0;
                            mf_s    = 1'b1;
                            err_s   = 1'b1;
                        end else begin
                            home_cnt_s = home_cnt_r + HCW'(1);
                        end
                    end else begin
                        home_cnt_s = home_cnt_r;
                    end
                end else begin
                    half_cnt_s = half_cnt_r + HW'(1);
                end
            end
            S_IDLE: begin
                pu_s = 1'b0;
                if (tgt_valid && ready_r) begin
                    if (tgt_pos > POS_MAX) begin
                        err_s = 1'b1;
                    end else if (tgt_pos == pos_r) begin
                        done_s = 1'b1;
                    end else begin
                        target_s = tgt_pos;
                        dr_s     = (tgt_pos > pos_r);
                        state_s  = S_SETUP;
                    end
                end else begin
                    target_s = target_r;
                end
            end
            S_SETUP: begin
                // first pulse rises as MOVE is entered
                pu_s       = 1'b1;
                half_cnt_s = '0;
                step_cnt_s = '0;
                state_s    = S_MOVE;
            end
            S_MOVE: begin
                if (stop_sync_r && !dr_r) begin
                    pu_s    = 1'b0;
                    pos_s   = 10'd0;
                    done_s  = 1'b1;
                    state_s = S_IDLE;
                end else if (half_done_s) begin
                    half_cnt_s = '0;
                    if (pu_r) begin
                        pu_s = 1'b0;
                        if (step_cnt_r == STEP_LAST) begin
                            step_cnt_s = '0;
                            pos_s      = pos_step_s;
                            if (pos_step_s == target_r) begin
                                done_s  = 1'b1;
                                state_s = S_IDLE;
                            end else begin
                                state_s = S_MOVE;
                            end
                        end else begin
                            step_cnt_s = step_cnt_r + SW'(1);
                        end
                    end else begin
                        pu_s = 1'b1;
                    end
                end else begin
                    half_cnt_s = half_cnt_r + HW'(1);
                end
            end
            S_FAULT: begin
                pu_s  = 1'b0;
                mf_s  = 1'b1;
                err_s = 1'b1;
            end
            default: begin
                state_s = S_FAULT;
                pu_s    = 1'b0;
                mf_s    = 1'b1;
                err_s   = 1'b1;
            end
        endcase
        ready_s = (state_s == S_IDLE) && homed_s;
    end

    // State and registered-output update
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_HOME;
            half_cnt_r <= '0;
            step_cnt_r <= '0;
            home_cnt_r <= '0;
            target_r   <= 10'd0;
            pos_r      <= 10'd0;
            pu_r       <= 1'b0;
            dr_r       <= 1'b0;
            mf_r       <= 1'b1;
            homed_r    <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            ready_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            half_cnt_r <= half_cnt_s;
            step_cnt_r <= step_cnt_s;
            home_cnt_r <= home_cnt_s;
            target_r   <= target_s;
            pos_r      <= pos_s;
            pu_r       <= pu_s;
            dr_r       <= dr_s;
            mf_r       <= mf_s;
            homed_r    <= homed_s;
            done_r     <= done_s;
            err_r      <= err_s;
            ready_r    <= ready_s;
        end
    end

    assign tgt_ready = ready_r;
    assign PU        = pu_r;
    assign DR        = dr_r;
    assign MF        = mf_r;
    assign cur_pos   = pos_r;
    assign homed     = homed_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_motor_axis_driver.sv
// -----------------------------------------------------------------------------
// tb_motor_axis_driver
// Scoreboard bench: every accepted target pushes its expected completion
// (done or err, with the expected final coordinate) onto a queue; a monitor
// pops and compares whenever the DUT pulses done or err. Step timing, pulse
// counts and homing are checked inline. A second instance with a short
// homing timeout exercises the FAULT path.
// -----------------------------------------------------------------------------
module tb_motor_axis_driver;

    localparam int HP  = 4;
    localparam int SPU = 2;

    typedef struct packed {
        logic       is_err;
        logic [9:0] pos;
    } exp_t;

    logic       sysclk = 1'b0;
    logic       rst_n, stop, tgt_valid;
    logic [9:0] tgt_pos;
    logic       tgt_ready, pu, dr, mf, homed, done, err;
    logic [9:0] cur_pos;

    logic       to_rst_n, to_stop, to_valid;
    logic [9:0] to_tgt;
    logic       to_ready, to_pu, to_dr, to_mf, to_homed, to_done, to_err;
    logic [9:0] to_pos;

    int   checks   = 0;
    int   failures = 0;
    int   pu_rises = 0;
    logic pu_prev  = 1'b0;
    logic done_prev = 1'b0;
    logic err_prev  = 1'b0;
    exp_t exp_q[$];

    always #5 sysclk = ~sysclk;

    motor_axis_driver #(.HALF_PERIOD(HP), .STEPS_PER_UNIT(SPU), .HOME_TIMEOUT(2048)) dut (
        .sysclk(sysclk), .rst_n(rst_n), .Stop(stop), .tgt_valid(tgt_valid),
        .tgt_pos(tgt_pos), .tgt_ready(tgt_ready), .PU(pu), .DR(dr), .MF(mf),
        .cur_pos(cur_pos), .homed(homed), .done(done), .err(err)
    );

    motor_axis_driver #(.HALF_PERIOD(HP), .STEPS_PER_UNIT(SPU), .HOME_TIMEOUT(16)) dut_to (
        .sysclk(sysclk), .rst_n(to_rst_n), .Stop(to_stop), .tgt_valid(to_valid),
        .tgt_pos(to_tgt), .tgt_ready(to_ready), .PU(to_pu), .DR(to_dr), .MF(to_mf),
        .cur_pos(to_pos), .homed(to_homed), .done(to_done), .err(to_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Scoreboard monitor: pops an expectation on every done/err pulse
    always @(negedge sysclk) begin
        if (rst_n) begin
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {30'd0, done, err}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("event_kind", {31'd0, err}, {31'd0, e.is_err});
                    check("event_pos", {22'd0, cur_pos}, {22'd0, e.pos});
                end
            end
            if (done) check("done_one_cycle", {31'd0, done_prev}, 32'd0);
            if (err)  check("err_one_cycle", {31'd0, err_prev}, 32'd0);
            if (pu && !pu_prev) pu_rises++;
        end
        pu_prev   = pu;
        done_prev = done;
        err_prev  = err;
    end

    // Drive one real move and check its step timing, pulse count and result
    task automatic do_move(input logic [9:0] tgt, input logic [9:0] exp_end,
                           input int exp_pulses, input logic exp_dr,
                           input int stop_at, input int stop_len);
        int         r0, last_chg, n_chg;
        logic [9:0] prev;
        logic       dr_bad, got_done, abort_mode;
        abort_mode = (stop_at > 0) && !exp_dr;
        dr_bad   = 1'b0;
        got_done = 1'b0;
        n_chg    = 0;
        last_chg = 0;
        exp_q.push_back('{is_err: 1'b0, pos: exp_end});
        tgt_valid = 1'b1;
        tgt_pos   = tgt;
        tick();
        tgt_valid = 1'b0;
        r0 = pu_rises;
        check("dr_after_accept", {31'd0, dr}, {31'd0, exp_dr});
        check("ready_low_setup", {31'd0, tgt_ready}, 32'd0);
        check("pu_low_setup", {31'd0, pu}, 32'd0);
        tick();
        check("pu_first_rise", {31'd0, pu}, 32'd1);
        prev = cur_pos;
        for (int i = 2; i < 3000 && !got_done; i++) begin
            if (stop_at > 0 && i == stop_at) stop = 1'b1;
            if (stop_at > 0 && i == stop_at + stop_len) stop = 1'b0;
            tick();
            if (dr !== exp_dr) dr_bad = 1'b1;
            if (cur_pos !== prev && !abort_mode) begin
                check("step_value", {22'd0, cur_pos}, {22'd0, exp_dr ? prev + 10'd1 : prev - 10'd1});
                if (n_chg == 0)
                    check("first_step_time", i, 1 + HP + (SPU - 1) * 2 * HP);
                else
                    check("step_interval", i - last_chg, 2 * HP * SPU);
                last_chg = i;
                n_chg++;
                prev = cur_pos;
            end
            if (done) got_done = 1'b1;
        end
        stop = 1'b0;
        check("move_done_seen", {31'd0, got_done}, 32'd1);
        check("dr_stable", {31'd0, dr_bad}, 32'd0);
        check("pulse_count", pu_rises - r0, exp_pulses);
        check("final_pos", {22'd0, cur_pos}, {22'd0, exp_end});
        tick();
        check("ready_after_move", {31'd0, tgt_ready}, 32'd1);
        check("pu_low_idle", {31'd0, pu}, 32'd0);
        check("mf_idle", {31'd0, mf}, 32'd0);
    endtask

    // Offer a target that must complete without motion (illegal or null)
    task automatic no_move(input logic [9:0] tgt, input logic is_err);
        int         r0;
        logic [9:0] p0;
        p0 = cur_pos;
        exp_q.push_back('{is_err: is_err, pos: p0});
        tgt_valid = 1'b1;
        tgt_pos   = tgt;
        tick();
        tgt_valid = 1'b0;
        r0 = pu_rises;
        check("err_pulse", {31'd0, err}, {31'd0, is_err});
        check("done_pulse", {31'd0, done}, {31'd0, ~is_err});
        check("stay_idle_ready", {31'd0, tgt_ready}, 32'd1);
        repeat (6) tick();
        check("no_pu", pu_rises - r0, 0);
        check("pos_held", {22'd0, cur_pos}, {22'd0, p0});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int rise_a, rise_b, n_rise, dr_seen, fault_at;
        logic pp;
        rst_n = 1'b0; stop = 1'b0; tgt_valid = 1'b0; tgt_pos = 10'd0;
        to_rst_n = 1'b0; to_stop = 1'b0; to_valid = 1'b0; to_tgt = 10'd0;
        repeat (3) tick();
        check("reset_flags", {25'd0, pu, dr, mf, homed, done, err, tgt_ready}, 32'b0010000);
        check("reset_pos", {22'd0, cur_pos}, 32'd0);

        // homing: release reset, watch the pulse train, then trip the switch
        rst_n = 1'b1;
        tick();
        check("home_first_cycle", {28'd0, pu, dr, mf, tgt_ready}, 32'd0);
        rise_a = -1; rise_b = -1; n_rise = 0; dr_seen = 0; pp = pu;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (dr !== 1'b0) dr_seen++;
            if (pu && !pp) begin
                rise_a = rise_b;
                rise_b = i;
                n_rise++;
            end
            pp = pu;
        end
        check("home_rises_seen", {31'd0, n_rise >= 2}, 32'd1);
        check("home_period", rise_b - rise_a, 2 * HP);
        check("home_dr_low", dr_seen, 0);
        check("home_not_homed", {31'd0, homed}, 32'd0);
        stop = 1'b1;
        repeat (3) tick();
        stop = 1'b0;
        check("homed_pu", {31'd0, pu}, 32'd0);
        check("homed_flag", {31'd0, homed}, 32'd1);
        check("homed_pos", {22'd0, cur_pos}, 32'd0);
        check("homed_ready", {31'd0, tgt_ready}, 32'd1);
        repeat (3) tick();

        do_move(10'd3, 10'd3, 6, 1'b1, 0, 0);
        do_move(10'd1, 10'd1, 4, 1'b0, 0, 0);
        no_move(10'd1023, 1'b1);
        no_move(10'd1, 1'b0);
        do_move(10'd5, 10'd5, 8, 1'b1, 0, 0);
        // downward move aborted by the limit switch while PU is high
        do_move(10'd2, 10'd0, 5, 1'b0, 32, 4);
        repeat (3) tick();
        // upward move ignores the limit switch
        do_move(10'd2, 10'd2, 4, 1'b1, 10, 4);

        // reset in the middle of a move discards target and position
        tgt_valid = 1'b1;
        tgt_pos   = 10'd6;
        tick();
        tgt_valid = 1'b0;
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        check("midmove_reset_flags", {25'd0, pu, dr, mf, homed, done, err, tgt_ready}, 32'b0010000);
        check("midmove_reset_pos", {22'd0, cur_pos}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rehome_mf", {31'd0, mf}, 32'd0);
        check("rehome_ready", {31'd0, tgt_ready}, 32'd0);
        check("scoreboard_drained", exp_q.size(), 0);

        // homing timeout on the short-timeout instance
        check("to_reset_mf", {31'd0, to_mf}, 32'd1);
        to_rst_n = 1'b1;
        fault_at = -1;
        for (int i = 1; i <= 500 && fault_at < 0; i++) begin
            tick();
            if (to_mf) fault_at = i;
        end
        check("to_fault_time", fault_at, 16 * 2 * HP);
        repeat (20) tick();
        check("to_fault_hold", {28'd0, to_mf, to_err, to_pu, to_ready}, 32'b1100);
        check("to_fault_homed", {31'd0, to_homed}, 32'd0);
        to_rst_n = 1'b0;
        #1;
        check("to_reset_exit", {30'd0, to_mf, to_err}, 32'b10);
        tick();
        to_rst_n = 1'b1;
        tick();
        check("to_home_again", {30'd0, to_mf, to_err}, 32'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/motor_axis_driver.md
MOTOR_AXIS_DRIVER -- requirements
Module: motor_axis_driver

Interface
REQ-001 Parameter HALF_PERIOD, default 4: sysclk cycles per PU high phase and per PU low phase.
REQ-002 Parameter STEPS_PER_UNIT, default 2: PU pulses per coordinate unit.
REQ-003 Parameter HOME_TIMEOUT, default 2048: maximum PU pulses issued while homing.
REQ-004 sysclk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Stop  in  1  home limit switch, active-high, asynchronous to sysclk.
REQ-007 tgt_valid  in  1  target coordinate offered.
REQ-008 tgt_pos  in  10  target coordinate, binary; legal range 0..999.
REQ-009 tgt_ready  out  1  high while a target can be accepted.
REQ-010 PU  out  1  step pulse to the motor driver.
REQ-011 DR  out  1  direction: 1 = away from home (position increasing), 0 = toward home.
REQ-012 MF  out  1  motor free: 1 = driver de-energized, 0 = energized.
REQ-013 cur_pos  out  10  current coordinate, binary.
REQ-014 homed  out  1  high once a home position has been established.
REQ-015 done  out  1  one-cycle pulse when a move finishes or a null move is accepted.
REQ-016 err  out  1  one-cycle pulse on an illegal target; held high in FAULT.

Function
REQ-017 Stop SHALL pass through a 2-flop synchronizer; all Stop references below mean the synchronized value.
REQ-018 The FSM SHALL use the states HOME, IDLE, SETUP, MOVE, FAULT.
REQ-019 HOME: MF=0, DR=0, PU toggles every HALF_PERIOD cycles, starting low.
REQ-020 HOME exit on Stop=1: PU low on the next cycle, cur_pos=0, homed=1, enter IDLE; a partial pulse is abandoned.
REQ-021 HOME exit once HOME_TIMEOUT falling PU edges have been counted without Stop: enter FAULT.
REQ-022 FAULT: MF=1, PU=0, err=1, tgt_ready=0; FAULT SHALL exit only through reset.
REQ-023 tgt_ready SHALL be 1 exactly when state is IDLE and homed=1.
REQ-024 A target is accepted on a cycle with tgt_valid=1 and tgt_ready=1; tgt_pos is captured on that cycle.
REQ-025 If the accepted tgt_pos exceeds 999: err pulses one cycle, the target is discarded, state stays IDLE.
REQ-026 If the accepted tgt_pos equals cur_pos: done pulses one cycle, state stays IDLE, no PU.
REQ-027 Otherwise: next state SETUP; DR=1 if tgt_pos>cur_pos, else 0; DR is valid 1 cycle after acceptance.
REQ-028 SETUP SHALL last exactly one cycle; the first PU rise occurs 2 cycles after acceptance.
REQ-029 MOVE: PU is high for HALF_PERIOD cycles, then low for HALF_PERIOD cycles; a pulse is counted at its falling edge.
REQ-030 After every STEPS_PER_UNIT counted pulses, cur_pos SHALL change by +1 (DR=1) or -1 (DR=0) on the same cycle.
REQ-031 When cur_pos reaches the target: done pulses on that cycle, PU stays low, the state returns to IDLE, and tgt_ready=1 on the next cycle.
REQ-032 DR SHALL not change while in MOVE.
REQ-033 Stop=1 in MOVE with DR=0: abort; PU low, cur_pos=0, done pulses, IDLE.
REQ-034 Stop=1 in MOVE with DR=1, or in IDLE: ignored.
REQ-035 In IDLE, MF=0 and PU=0; DR holds its last value.
REQ-036 cur_pos SHALL never exceed 999 or go below 0.

Reset
REQ-037 While rst_n=0, all outputs SHALL take these values: PU=0, DR=0, MF=1, cur_pos=0, homed=0, done=0, err=0, tgt_ready=0; the state is HOME and all counters and synchronizer flops are cleared.
REQ-038 The first cycle after rst_n deasserts SHALL be in HOME with MF=0; a reset mid-move SHALL discard the target and the position.

Verification
REQ-039 Reset release, then Stop pulse after 100 cycles -> 8-cycle PU period with DR=0 before the pulse; within 3 cycles of Stop: PU=0, homed=1, cur_pos=0, tgt_ready=1.
REQ-040 Homed, target 3 accepted -> DR=1 next cycle; first PU rise 2 cycles after acceptance; 6 pulses; cur_pos steps 1,2,3 every 16 cycles; done on the cycle cur_pos=3.
REQ-041 At cur_pos=3, target 1 -> DR=0; 4 pulses; cur_pos 2 then 1; done pulses once; tgt_ready returns to 1.
REQ-042 Target 1023 at cur_pos=1 -> err pulses one cycle, no PU, cur_pos stays 1; target 1 -> done pulses, no PU.
REQ-043 Moving from 5 toward 0, Stop asserted mid-pulse -> PU low, cur_pos=0, done pulses, IDLE; Stop during an upward move -> no effect.
REQ-044 HOME_TIMEOUT=16 with Stop never asserted -> after the 16th falling PU edge: FAULT, MF=1, err=1 held; reset is the only exit.
